uart_tx_r0: RTL and testbench

- Serial UART transmitter; companion to the team's UART receiver. Its frame format matches the receiver's: configurable start-bit polarity, stop level = ~START_BIT, data sent MSB first.
- The receiver shifts new bits into its LSB, so a word sent MSB first arrives unchanged in the receiver's output register.
- Parallel word in over a start-request/busy handshake; serial line out. Sits between the host-side command logic and the external TX pin or an internal loopback.

---
 rtl/uart_tx_r0.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_r0.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_r0.sv
// uart_tx_r0 -- serial UART transmitter, companion to the team's UART receiver.
// Frame: start bit (START_BIT level), BIT_WIDTH data bits MSB first, stop bit
// (~START_BIT). Each bit is held for CLKS_PER_BIT clocks. The line, busy and
// all state are registered, so the line always matches the current state.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module uart_tx_r0 #(
    parameter int unsigned BIT_WIDTH    = 8,     // data bits per frame, 1..15
    parameter logic        START_BIT    = 1'b0,  // start-bit level; idle/stop = ~START_BIT
    parameter int unsigned CLKS_PER_BIT = 1      // clocks per serial bit, 1..65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] dataIn,
    input  logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic                 dataOut
);

    localparam int unsigned     BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      BIT_LAST  = 4'(BIT_WIDTH - 1);
    localparam logic            IDLE_LVL  = ~START_BIT;

    typedef enum logic [2:0] {
        s_IDLE,
        s_START,
        s_DATA,
        s_STOP
`ifdef UART_TX_PARITY_EN
        , s_PARITY
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [BIT_WIDTH-1:0]   shift_q, shift_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic                   data_out_q, data_out_d;
    logic                   busy_q, busy_d;
    logic                   done_c;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    // Last clock of the bit currently on the line.
    assign bit_end = (baud_q == BAUD_LAST);

    // Register all state; synchronous reset returns the line to idle and
    // discards any frame in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= s_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_q     <= '0;
            data_out_q <= IDLE_LVL;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_q     <= baud_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Next-state logic, datapath updates and the registered line/busy values.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_c    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        unique case (state_q)
            s_IDLE: begin
                if (tx) begin
                    shift_d = dataIn;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^dataIn;
`endif
                    state_d = s_START;
                end
            end
            s_START: begin
                if (bit_end) begin
                    state_d   = s_DATA;
                    bit_cnt_d = '0;
                end
            end
            s_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = s_PARITY;
`else
                        state_d = s_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            s_PARITY: begin
                if (bit_end) begin
                    state_d = s_STOP;
                end
            end
`endif
            s_STOP: begin
                done_c = bit_end;
                if (bit_end) begin
                    if (tx) begin
                        // Back-to-back frame: re-sample the word, no idle gap.
                        shift_d = dataIn;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^dataIn;
`endif
                        state_d = s_START;
                    end else begin
                        state_d = s_IDLE;
                    end
                end
            end
            default: state_d = s_IDLE;
        endcase

        // Baud counter runs only inside a bit and restarts on every bit boundary.
        if (state_q == s_IDLE || bit_end || state_d != state_q) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        // Line level follows the state being entered, so it lines up with state_q.
        unique case (state_d)
            s_START: data_out_d = START_BIT;
            s_DATA:  data_out_d = shift_d[BIT_WIDTH-1];
`ifdef UART_TX_PARITY_EN
            s_PARITY: data_out_d = parity_d;
`endif
            default: data_out_d = IDLE_LVL;
        endcase
        busy_d = (state_d != s_IDLE);
    end

    assign dataOut = data_out_q;
    assign busy    = busy_q;
    assign done    = done_c;

endmodule

// File: tb/tb_uart_tx_r0.sv
// tb_uart_tx_r0 -- self-checking bench for uart_tx_r0.
// Two instances: dut_a (CLKS_PER_BIT = 1, also looped back into a small
// receiver model) and dut_b (CLKS_PER_BIT = 4). Expected line samples and
// expected received words are queued when stimulus is driven and popped as
// the DUTs produce output. Honours UART_TX_PARITY_EN if defined.
`timescale 1ns/1ps
module tb_uart_tx_r0;

    localparam int BW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = BW + 2 + PAR;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_a = 1'b0, tx_b = 1'b0;
    logic [BW-1:0] din_a = '0, din_b = '0;
    logic          busy_a, done_a, line_a;
    logic          busy_b, done_b, line_b;
    logic          rx_en = 1'b0;

    uart_tx_r0 #(.BIT_WIDTH(BW), .START_BIT(1'b0), .CLKS_PER_BIT(1)) dut_a (
        .clk(clk), .rst(rst), .dataIn(din_a), .tx(tx_a),
        .busy(busy_a), .done(done_a), .dataOut(line_a)
    );

    uart_tx_r0 #(.BIT_WIDTH(BW), .START_BIT(1'b0), .CLKS_PER_BIT(4)) dut_b (
        .clk(clk), .rst(rst), .dataIn(din_b), .tx(tx_b),
        .busy(busy_b), .done(done_b), .dataOut(line_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy;
        logic done;
        logic line;
    } obs_t;

    obs_t          exp_q[$];
    logic [BW-1:0] rx_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.busy = busy_a; o.done = done_a; o.line = line_a;
        end else begin
            o.busy = busy_b; o.done = done_b; o.line = line_b;
        end
        return o;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o;
        o.busy = 1'b0; o.done = 1'b0; o.line = 1'b1;
        return o;
    endfunction

    task automatic drive(input int sel, input logic t, input logic [BW-1:0] d);
        if (sel == 0) begin
            tx_a = t; din_a = d;
        end else begin
            tx_b = t; din_b = d;
        end
    endtask

    // Reference frame: start 0, data MSB first, optional even parity, stop 1.
    task automatic push_frame(input logic [BW-1:0] w, input int cpb);
        logic bits[$];
        obs_t o;
        bits.push_back(1'b0);
        for (int k = BW - 1; k >= 0; k--) bits.push_back(w[k]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^w);
`endif
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < cpb; c++) begin
                o.busy = 1'b1;
                o.done = (b == bits.size() - 1) && (c == cpb - 1);
                o.line = bits[b];
                exp_q.push_back(o);
            end
        end
    endtask

    // Send one or two frames (two = tx held high, back to back) and compare
    // the line, busy and done every clock, then confirm the return to idle.
    task automatic run_stream(input int sel, input int cpb, input logic [BW-1:0] w0,
                              input logic [BW-1:0] w1, input int nframes);
        int   total;
        obs_t e;
        obs_t got;
        push_frame(w0, cpb);
        if (nframes > 1) push_frame(w1, cpb);
        if (sel == 0) begin
            rx_q.push_back(w0);
            if (nframes > 1) rx_q.push_back(w1);
        end
        total = exp_q.size();
        @(negedge clk);
        drive(sel, 1'b1, w0);
        @(negedge clk);
        for (int i = 0; i < total; i++) begin
            e   = exp_q.pop_front();
            got = sample(sel);
            check($sformatf("dut%0d_w%02h_cyc%0d", sel, w0, i + 1), 32'(got), 32'(e));
            // Disturb dataIn mid-frame; only the stop bit-end sample may use it.
            if (i == 0) begin
                if (nframes > 1) drive(sel, 1'b1, w1);
                else             drive(sel, 1'b0, ~w0);
            end else if (i == FLEN * cpb) begin
                drive(sel, 1'b0, ~w1);
            end
            @(negedge clk);
        end
        check($sformatf("dut%0d_w%02h_idle", sel, w0), 32'(sample(sel)), 32'(idle_obs()));
    endtask

    // Loopback receiver on dut_a: shifts each data bit into its LSB.
    int            rx_st = 0;
    logic [BW-1:0] rx_sh = '0;
    always @(negedge clk) begin
        if (!rx_en) begin
            rx_st <= 0;
        end else if (rx_st == 0) begin
            if (line_a == 1'b0) rx_st <= 1;
        end else if (rx_st <= BW) begin
            rx_sh <= {rx_sh[BW-2:0], line_a};
            rx_st <= rx_st + 1;
`ifdef UART_TX_PARITY_EN
        end else if (rx_st == BW + 1) begin
            check("rx_parity", 32'(line_a), 32'(^rx_sh));
            rx_st <= rx_st + 1;
`endif
        end else begin
            check("rx_stop", 32'(line_a), 32'(1));
            if (rx_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rx_unexpected: got 0x%0h, expected no word", rx_sh);
            end else begin
                check("rx_word", 32'(rx_sh), 32'(rx_q.pop_front()));
            end
            rx_st <= 0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_a", 32'(sample(0)), 32'(idle_obs()));
        check("reset_b", 32'(sample(1)), 32'(idle_obs()));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle_a_%0d", i), 32'(sample(0)), 32'(idle_obs()));
            check($sformatf("idle_b_%0d", i), 32'(sample(1)), 32'(idle_obs()));
        end
        rx_en = 1'b1;

        run_stream(0, 1, 8'hA5, 8'h00, 1);
        run_stream(0, 1, 8'h07, 8'h00, 1);
        run_stream(1, 4, 8'h81, 8'h00, 1);
        run_stream(0, 1, 8'h3C, 8'hC3, 2);

        // Reset during data bit 4 of 0xFF: frame dropped, no done pulse.
        rx_en = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(0, 1'b0, 8'hFF);
        repeat (5) @(negedge clk);
        check("midrst_bit4_line", 32'(line_a), 32'(1));
        check("midrst_bit4_busy", 32'(busy_a), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_next", 32'(sample(0)), 32'(idle_obs()));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midrst_idle_%0d", i), 32'(sample(0)), 32'(idle_obs()));
        end
        rx_en = 1'b1;
        run_stream(0, 1, 8'h00, 8'h00, 1);

        repeat (2) @(negedge clk);
        check("rx_drained", 32'(rx_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
